// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath -- Mini SRC phase-1 datapath.
//
// Sixteen 32-bit general-purpose registers (R0-R15), a memory data register
// (MDR) and one shared bus. An encoded source mux drives the bus. Data comes
// in through MDR, from Mdatain or from the bus, and is copied into a GP
// register over the bus.
//
// Ports:
//   clock          system clock; all state updates on the rising edge
//   clear          synchronous active-high reset of R0-R15 and MDR
//   reg_addr       GP register index written when e_GP=1
//   Mdatain        memory read data, the MDR source when read=1
//   read           MDR source select: 1 = Mdatain, 0 = bus
//   e_GP           GP register write enable
//   e_MDR          MDR load enable
//   BusDataSelect  bus source code (0-15 = R0-R15, 21 = MDR, others = 0)
//   bus_out        current bus value (combinational)
//   mdr_out        current MDR contents
// -----------------------------------------------------------------------------

// One enable-loaded register with synchronous clear. clear wins over en.
module datapath_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (clear)   q <= '0;
        else if (en) q <= d;
    end
endmodule

module datapath #(
    parameter int WIDTH  = 32,
    parameter int NUM_GP = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [3:0]       reg_addr,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             read,
    input  logic             e_GP,
    input  logic             e_MDR,
    input  logic [4:0]       BusDataSelect,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] mdr_out
);
    localparam logic [4:0] SEL_MDR = 5'b10101;

    logic [NUM_GP-1:0][WIDTH-1:0] gp;
    logic [NUM_GP-1:0]            gp_en;
    logic [WIDTH-1:0]             mdr_d;

    // GP file: every register samples the bus, only the addressed one loads.
    for (genvar i = 0; i < NUM_GP; i++) begin : g_gp
        assign gp_en[i] = e_GP && (reg_addr == 4'(i));

        datapath_reg #(.WIDTH(WIDTH)) u_gp (
            .clock (clock),
            .clear (clear),
            .en    (gp_en[i]),
            .d     (bus_out),
            .q     (gp[i])
        );
    end

    assign mdr_d = read ? Mdatain : bus_out;

    datapath_reg #(.WIDTH(WIDTH)) u_mdr (
        .clock (clock),
        .clear (clear),
        .en    (e_MDR),
        .d     (mdr_d),
        .q     (mdr_out)
    );

    // The bus reads only register outputs, so writing the selected register
    // from the bus is loop-free: the new value appears after the edge.
    // Codes 16-20, 22-31 are reserved for later sources and drive zero.
    always_comb begin
        bus_out = '0;
        if (!BusDataSelect[4])
            bus_out = gp[BusDataSelect[3:0]];
        else if (BusDataSelect == SEL_MDR)
            bus_out = mdr_out;
    end
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
    logic        clock = 1'b0;
    logic        clear;
    logic [3:0]  reg_addr;
    logic [31:0] Mdatain;
    logic        read;
    logic        e_GP;
    logic        e_MDR;
    logic [4:0]  BusDataSelect;
    logic [31:0] bus_out;
    logic [31:0] mdr_out;

    int n_vec = 0;
    int n_err = 0;

    datapath dut (
        .clock         (clock),
        .clear         (clear),
        .reg_addr      (reg_addr),
        .Mdatain       (Mdatain),
        .read          (read),
        .e_GP          (e_GP),
        .e_MDR         (e_MDR),
        .BusDataSelect (BusDataSelect),
        .bus_out       (bus_out),
        .mdr_out       (mdr_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One rising edge; inputs then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; e_GP = 1'b0; e_MDR = 1'b0;
    endtask

    // Load MDR from Mdatain, then copy it into R[idx] over the bus.
    task automatic load_reg(input logic [3:0] idx, input logic [31:0] val);
        idle();
        read = 1'b1; BusDataSelect = 5'b10101; Mdatain = val;
        e_MDR = 1'b1; step(); e_MDR = 1'b0;
        chk($sformatf("mdr_load_%0d", idx), mdr_out, val);
        reg_addr = idx; e_GP = 1'b1; step(); e_GP = 1'b0;
    endtask

    logic [31:0] ld_val [3];
    logic [4:0]  rsv    [6];

    initial begin
        ld_val = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE};
        rsv    = '{5'b10000, 5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11111};
        reg_addr = '0; Mdatain = '0; read = 1'b0; BusDataSelect = 5'b10101;

        // Reset with unknown enables.
        @(negedge clock);
        clear = 1'b1; e_GP = 1'bx; e_MDR = 1'bx; Mdatain = 32'h5A5A5A5A; read = 1'b1;
        step();
        idle();
        chk("rst_mdr", mdr_out, 32'h0);
        chk("rst_bus_mdr", bus_out, 32'h0);
        for (int i = 0; i < 16; i++) begin
            BusDataSelect = 5'(i); #1;
            chk($sformatf("rst_r%0d", i), bus_out, 32'h0);
        end

        // Load R0..R2 through MDR.
        for (int i = 0; i < 3; i++) load_reg(4'(i), ld_val[i]);
        for (int i = 0; i < 3; i++) begin
            BusDataSelect = 5'(i); #1;
            chk($sformatf("bus_r%0d", i), bus_out, ld_val[i]);
        end

        // MDR from the bus; Mdatain must be ignored.
        BusDataSelect = 5'd1; read = 1'b0; Mdatain = 32'hFFFFFFFF;
        e_MDR = 1'b1; step(); e_MDR = 1'b0;
        chk("mdr_from_bus", mdr_out, 32'h12345678);

        // MDR reloading itself from the bus holds its value.
        BusDataSelect = 5'b10101; read = 1'b0;
        e_MDR = 1'b1; step(); e_MDR = 1'b0;
        chk("mdr_self_hold", mdr_out, 32'h12345678);
        #1 chk("bus_mdr", bus_out, 32'h12345678);

        // Simultaneous enables: R15 gets old MDR, MDR gets Mdatain.
        read = 1'b1; Mdatain = 32'hAAAA5555;
        e_MDR = 1'b1; step(); e_MDR = 1'b0;
        Mdatain = 32'h11112222; reg_addr = 4'd15;
        e_MDR = 1'b1; e_GP = 1'b1; step(); idle();
        chk("simul_mdr", mdr_out, 32'h11112222);
        BusDataSelect = 5'd15; #1;
        chk("simul_r15", bus_out, 32'hAAAA5555);
        BusDataSelect = 5'd1; #1;
        chk("r1_untouched", bus_out, 32'h12345678);

        // Register-to-register copy over the bus (R15 -> R3).
        BusDataSelect = 5'd15; reg_addr = 4'd3; e_GP = 1'b1; step(); e_GP = 1'b0;
        BusDataSelect = 5'd3; #1;
        chk("copy_r3", bus_out, 32'hAAAA5555);

        // Write R0 (ordinary register) from R2 while R0 is not on bus.
        BusDataSelect = 5'd2; reg_addr = 4'd0; e_GP = 1'b1; step(); e_GP = 1'b0;
        BusDataSelect = 5'd0; #1;
        chk("r0_rewrite", bus_out, 32'hCAFEBABE);

        // Reserved codes drive zero.
        foreach (rsv[k]) begin
            BusDataSelect = rsv[k]; #1;
            chk($sformatf("rsv_%05b", rsv[k]), bus_out, 32'h0);
        end

        // Reset mid-operation beats pending enables.
        BusDataSelect = 5'd15; read = 1'b1; Mdatain = 32'h87654321; reg_addr = 4'd4;
        clear = 1'b1; e_GP = 1'b1; e_MDR = 1'b1; step(); idle();
        chk("midrst_mdr", mdr_out, 32'h0);
        for (int i = 0; i < 16; i++) begin
            BusDataSelect = 5'(i); #1;
            chk($sformatf("midrst_r%0d", i), bus_out, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Phase-1 datapath of the Mini SRC CPU.
- Contains 16 general-purpose 32-bit registers R0–R15, a 32-bit memory data register (MDR) and a single 32-bit shared bus driven by an encoded source multiplexer.
- Data enters through MDR from the memory-data input (or from the bus) and is copied into a GP register over the bus.
- Any register can be placed on the bus for observation; later phases add an ALU, HI/LO, Z, PC and I/O sources on the reserved bus codes.

Parameters:
- WIDTH, 32, data width of the bus, MDR and GP registers.
- NUM_GP, 16, number of general-purpose registers; address width is 4.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- reg_addr  input  4  GP register index written when e_GP=1.
- Mdatain  input  WIDTH  memory read data, the MDR source when read=1.
- read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
- e_GP  input  1  write enable for GP register R[reg_addr].
- e_MDR  input  1  MDR load enable.
- BusDataSelect  input  5  bus source code.
- bus_out  output  WIDTH  current bus value, combinational.
- mdr_out  output  WIDTH  current MDR contents.

Behaviour:
- Reset: on a rising edge with clear=1, R0–R15 and MDR go to 0.
  - clear has priority over e_GP and e_MDR; X on the enables is ignored while clear=1.
  - bus_out follows the mux from the cleared registers (0 for every valid code after reset).
- MDR: on a rising edge with clear=0 and e_MDR=1, MDR <= (read ? Mdatain : bus); otherwise it holds. Latency is 1 edge.
- GP write: on a rising edge with clear=0 and e_GP=1, R[reg_addr] <= bus; the other registers hold.
  - R0 is an ordinary register, not hardwired to zero.
- Bus mux (combinational, zero latency), by BusDataSelect:
  - 00000–01111: R0–R15 (code = register index).
  - 10101: MDR.
  - 10000–10100, 10110, 10111: reserved (HI, LO, Zhigh, Zlow, PC, —, InPort, C_sign_ext); drive 0.
  - 11000–11111: drive 0.
- Simultaneous e_MDR=1 and e_GP=1 with BusDataSelect=MDR: the GP register gets the pre-edge MDR value and MDR gets its new value (both read the pre-edge bus).
- MDR loading from the bus (read=0) with BusDataSelect=MDR holds the MDR value unchanged.
- A GP write to the register currently selected on the bus: bus_out shows the new value after the edge, with no combinational loop (the bus depends only on register outputs).
- All 32 bits are passed unmodified; there is no sign extension or arithmetic in this block.
- A reset asserted mid-sequence clears all state on that edge regardless of pending enables.

Test Plan:
- Reset: clear=1 for one edge with e_GP/e_MDR=X, BusDataSelect=10101 -> mdr_out=0, bus_out=0; then BusDataSelect=00000..01111 -> bus_out=0 for each.
- Load/transfer: read=1, BusDataSelect=10101.
  - Mdatain=DEADBEEF, e_MDR=1 for one edge -> mdr_out=DEADBEEF.
  - e_GP=1, reg_addr=0 for one edge -> R0=DEADBEEF.
  - Repeat with 12345678 into R1 and CAFEBABE into R2.
  - BusDataSelect=00000/00001/00010 -> bus_out=DEADBEEF/12345678/CAFEBABE.
- Bus-sourced MDR: BusDataSelect=00001, read=0, e_MDR=1 -> mdr_out=12345678; Mdatain is ignored.
- Simultaneous enables: MDR=AAAA5555, BusDataSelect=10101, Mdatain=11112222, read=1, e_MDR=e_GP=1, reg_addr=15 -> R15=AAAA5555, MDR=11112222.
- Reserved codes: BusDataSelect=10000, 10100, 10111, 11111 with nonzero registers -> bus_out=00000000.
- Reset mid-operation: registers loaded, then clear=1 together with e_GP=1 and e_MDR=1 -> after that edge every register and MDR = 0.
